// File: rtl/piton_loopback_net.sv
// Single-tile loopback endpoint for the OpenPiton raw NoC link: buffers whole
// packets from the FU (store-and-forward) and returns them unchanged.
module piton_loopback_net #(
    parameter int DEPTH  = 16,
    parameter int FLIT_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     noc_out_val,
    output logic                     noc_out_rdy,
    input  logic [FLIT_W-1:0]        noc_out_data,
    output logic                     noc_in_val,
    input  logic                     noc_in_rdy,
    output logic [FLIT_W-1:0]        noc_in_data,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic                     err_oversize
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int unsigned DEPTH_U = DEPTH;

    typedef enum logic [1:0] {RX_HEAD, RX_BODY, RX_DROP} rx_state_e;
    typedef enum logic       {TX_IDLE, TX_BODY}          tx_state_e;

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     occ_q, pkt_cnt_q;
    logic              err_q, err_d;
    rx_state_e         rx_state_q, rx_state_d;
    tx_state_e         tx_state_q, tx_state_d;
    logic [7:0]        rx_rem_q, rx_rem_d, tx_rem_q, tx_rem_d;

    logic       in_xfer, push, pop, pkt_inc, pkt_dec, oversize;
    logic [7:0] in_len, head_len;

    assign in_len       = noc_out_data[29:22];
    assign head_len     = noc_in_data[29:22];
    // Length is 8 bits, so "length + 1 > DEPTH" reduces to this without overflow.
    assign oversize     = 32'(in_len) >= DEPTH_U;
    assign noc_out_rdy  = (rx_state_q == RX_DROP) || (occ_q != CW'(DEPTH));
    assign in_xfer      = noc_out_val && noc_out_rdy;
    assign noc_in_data  = mem_q[rd_ptr_q];
    assign pkt_count    = pkt_cnt_q;
    assign err_oversize = err_q;

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_rem_d   = rx_rem_q;
        err_d      = err_q;
        push       = 1'b0;
        pkt_inc    = 1'b0;
        case (rx_state_q)
            RX_HEAD: if (in_xfer) begin
                if (oversize) begin
                    err_d = 1'b1;
                    if (in_len != 8'd0) begin
                        rx_rem_d   = in_len;
                        rx_state_d = RX_DROP;
                    end
                end else begin
                    push = 1'b1;
                    if (in_len == 8'd0) begin
                        pkt_inc = 1'b1;
                    end else begin
                        rx_rem_d   = in_len;
                        rx_state_d = RX_BODY;
                    end
                end
            end
            RX_BODY: if (in_xfer) begin
                push     = 1'b1;
                rx_rem_d = rx_rem_q - 8'd1;
                if (rx_rem_q == 8'd1) begin
                    pkt_inc    = 1'b1;
                    rx_state_d = RX_HEAD;
                end
            end
            RX_DROP: if (in_xfer) begin
                rx_rem_d = rx_rem_q - 8'd1;
                if (rx_rem_q == 8'd1) rx_state_d = RX_HEAD;
            end
            default: rx_state_d = RX_HEAD;
        endcase
    end

    // A header is only offered once its whole packet is resident, so the body
    // stream never has to wait on the receive side.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_rem_d   = tx_rem_q;
        noc_in_val = 1'b0;
        pop        = 1'b0;
        pkt_dec    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                noc_in_val = (pkt_cnt_q != '0);
                if (noc_in_val && noc_in_rdy) begin
                    pop     = 1'b1;
                    pkt_dec = 1'b1;
                    if (head_len != 8'd0) begin
                        tx_rem_d   = head_len;
                        tx_state_d = TX_BODY;
                    end
                end
            end
            TX_BODY: begin
                noc_in_val = 1'b1;
                if (noc_in_rdy) begin
                    pop      = 1'b1;
                    tx_rem_d = tx_rem_q - 8'd1;
                    if (tx_rem_q == 8'd1) tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // NOTE: the flit array has no reset; occupancy and pointers alone define
    // which entries are valid, and a resettable RAM would cost a flop array.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= noc_out_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            pkt_cnt_q  <= '0;
            err_q      <= 1'b0;
            rx_state_q <= RX_HEAD;
            tx_state_q <= TX_IDLE;
            rx_rem_q   <= '0;
            tx_rem_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            occ_q      <= occ_q + CW'(push) - CW'(pop);
            pkt_cnt_q  <= pkt_cnt_q + CW'(pkt_inc) - CW'(pkt_dec);
            err_q      <= err_d;
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
            rx_rem_q   <= rx_rem_d;
            tx_rem_q   <= tx_rem_d;
        end
    end

endmodule

// File: tb/tb_piton_loopback_net.sv
// Scoreboard bench for piton_loopback_net: a packet-level model feeds an
// expected-flit queue that an independent output monitor drains and compares.
module tb_piton_loopback_net;

    localparam int DEPTH  = 16;
    localparam int FLIT_W = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              noc_out_val;
    logic              noc_out_rdy;
    logic [FLIT_W-1:0] noc_out_data;
    logic              noc_in_val;
    logic              noc_in_rdy;
    logic [FLIT_W-1:0] noc_in_data;
    logic [4:0]        pkt_count;
    logic              err_oversize;

    piton_loopback_net #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .noc_out_val  (noc_out_val),
        .noc_out_rdy  (noc_out_rdy),
        .noc_out_data (noc_out_data),
        .noc_in_val   (noc_in_val),
        .noc_in_rdy   (noc_in_rdy),
        .noc_in_data  (noc_in_data),
        .pkt_count    (pkt_count),
        .err_oversize (err_oversize)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q [$];   // flits the DUT must return, in order
    logic [63:0] part_q [$];  // packet currently being sent
    int          part_len;
    logic        exp_err;
    logic        rand_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Packet-level reference: a packet is returned whole iff it fits the buffer.
    task automatic model_accept(input logic [63:0] f);
        part_q.push_back(f);
        if (part_q.size() == 1) begin
            part_len = int'(f[29:22]) + 1;
            if (part_len > DEPTH) exp_err = 1'b1;
        end
        if (part_q.size() == part_len) begin
            if (part_len <= DEPTH) foreach (part_q[i]) exp_q.push_back(part_q[i]);
            part_q.delete();
        end
    endtask

    function automatic logic [63:0] mk_flit(input logic [7:0] len);
        logic [63:0] f;
        f = {$urandom(), $urandom()};
        f[29:22] = len;
        return f;
    endfunction

    // All driver tasks start and end at posedge + 1.
    task automatic send_flit(input logic [63:0] f);
        logic ok;
        int   n;
        noc_out_val  = 1'b1;
        noc_out_data = f;
        n = 0;
        forever begin
            @(negedge clk);
            ok = noc_out_rdy;
            @(posedge clk);
            #1;
            if (ok) begin
                model_accept(f);
                break;
            end
            n++;
            if (n > 3000) begin
                check("send_timeout", 64'(n), 64'd0);
                break;
            end
        end
        noc_out_val = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        if (!rand_rdy) noc_in_rdy = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || pkt_count != 0 || noc_in_val) && n < 3000) begin
            idle(1);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_rdy"}, noc_out_rdy, 1'b1);
        check({tag, "_in_val"}, noc_in_val, 1'b0);
        check({tag, "_pkt_count"}, pkt_count, 5'd0);
        check({tag, "_err"}, err_oversize, 1'b0);
    endtask

    // Output monitor: compares every returned flit and the stall rules.
    logic        prev_stall;
    logic [63:0] prev_data;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_val_held", noc_in_val, 1'b1);
                check("stall_data_stable", noc_in_data, prev_data);
            end
            if (noc_in_val && noc_in_rdy) begin
                if (exp_q.size() == 0) check("unexpected_out_flit", 64'(exp_q.size()), 64'd1);
                else check("out_flit", noc_in_data, exp_q.pop_front());
            end
            prev_stall = noc_in_val && !noc_in_rdy;
            prev_data  = noc_in_data;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) noc_in_rdy = ($urandom_range(0, 3) != 0);
    end

    initial begin
        logic [63:0] hdr;
        rst_n        = 1'b0;
        noc_out_val  = 1'b0;
        noc_out_data = '0;
        noc_in_rdy   = 1'b0;
        exp_err      = 1'b0;
        rand_rdy     = 1'b0;
        part_len     = 0;
        idle(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(1);

        // Single-flit echo with one-cycle latency.
        noc_in_rdy = 1'b1;
        send_flit(64'h0000_0000_0000_0AB0);
        check("t1_pkt_count_up", pkt_count, 5'd1);
        check("t1_latency_val", noc_in_val, 1'b1);
        idle(1);
        check("t1_pkt_count_down", pkt_count, 5'd0);
        check("t1_val_low", noc_in_val, 1'b0);
        drain();

        // 3-flit packet held by a stalled FU.
        noc_in_rdy = 1'b0;
        hdr = 64'(2) << 22;
        send_flit(hdr);
        send_flit(64'h11);
        check("t2_val_before_last", noc_in_val, 1'b0);
        send_flit(64'h22);
        check("t2_val_after_last", noc_in_val, 1'b1);
        check("t2_pkt_count", pkt_count, 5'd1);
        idle(3);
        check("t2_head_data", noc_in_data, hdr);
        drain();

        // Store-and-forward: bodies arrive late.
        send_flit(mk_flit(8'd2));
        send_flit(mk_flit(8'd9));
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("t3_val_waiting", noc_in_val, 1'b0);
        end
        send_flit(mk_flit(8'd7));
        check("t3_val_complete", noc_in_val, 1'b1);
        drain();

        // Fill the buffer with four 4-flit packets.
        noc_in_rdy = 1'b0;
        for (int p = 0; p < 4; p++) begin
            send_flit(mk_flit(8'd3));
            for (int b = 0; b < 3; b++) send_flit(mk_flit(8'($urandom_range(0, 255))));
        end
        check("t4_full_rdy", noc_out_rdy, 1'b0);
        check("t4_pkt_count", pkt_count, 5'd4);
        drain();
        check("t4_rdy_back", noc_out_rdy, 1'b1);

        // Oversize packet dropped, error sticky.
        send_flit(mk_flit(8'd16));
        for (int b = 0; b < 16; b++) begin
            check("t5_drop_rdy", noc_out_rdy, 1'b1);
            send_flit(mk_flit(8'($urandom_range(0, 255))));
        end
        check("t5_err_set", err_oversize, exp_err);
        check("t5_nothing_buffered", pkt_count, 5'd0);
        send_flit(mk_flit(8'd0));
        drain();
        check("t5_err_sticky", err_oversize, 1'b1);

        // Reset in the middle of a packet.
        noc_in_rdy = 1'b0;
        send_flit(mk_flit(8'd3));
        send_flit(mk_flit(8'd1));
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midreset");
        part_q.delete();
        exp_q.delete();
        exp_err = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        noc_in_rdy = 1'b1;
        send_flit(mk_flit(8'd0));
        drain();

        // Randomised traffic with a randomly stalling FU.
        rand_rdy = 1'b1;
        for (int p = 0; p < 150; p++) begin
            int r, len;
            r = $urandom_range(0, 9);
            if (r == 0)     len = $urandom_range(16, 24);
            else if (r < 4) len = 0;
            else            len = $urandom_range(1, 15);
            send_flit(mk_flit(8'(len)));
            for (int b = 0; b < len; b++) begin
                send_flit(mk_flit(8'($urandom_range(0, 255))));
                if ($urandom_range(0, 7) == 0) idle(1);
            end
        end
        drain();
        rand_rdy = 1'b0;
        idle(1);
        noc_in_rdy = 1'b1;
        drain();
        check("rand_err_flag", err_oversize, exp_err);
        check("rand_rdy_idle", noc_out_rdy, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
